// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier, one multiplier bit per cycle. Optional signed mode via MUL_SEQ_SIGNED_EN.
// Latency: done is seen WIDTH edges after the accepting edge. Result is held until the next one completes.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE), and is ignored while busy.
module mul_seq #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   out_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 last_bit;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   x_ext;
`ifdef MUL_SEQ_SIGNED_EN
    logic                 sgn_q;
`endif

    assign accept   = start && (state_q != S_RUN);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign pp       = mcand_q << cnt_q;

`ifdef MUL_SEQ_SIGNED_EN
    assign x_ext = {{WIDTH{x[WIDTH-1] & sgn}}, x};
    // In two's complement the multiplier MSB carries negative weight.
    always_comb begin
        acc_nxt = acc_q;
        if (mplier_q[0]) begin
            if (sgn_q && last_bit) acc_nxt = acc_q - pp;
            else                   acc_nxt = acc_q + pp;
        end
    end
`else
    assign x_ext   = {{WIDTH{1'b0}}, x};
    assign acc_nxt = mplier_q[0] ? (acc_q + pp) : acc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Flags are decoded from the next state so the ports are driven straight from flops.
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            out_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                mcand_q  <= x_ext;
                mplier_q <= y;
                cnt_q    <= '0;
                acc_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
                sgn_q    <= sgn;
`endif
            end else if (state_q == S_RUN) begin
                acc_q    <= acc_nxt;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (last_bit) out_q <= acc_nxt;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mul_seq.sv
// Randomised + directed bench for mul_seq: arithmetic reference model, scoreboard queue and a negedge monitor.
module tb_mul_seq;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;

    mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
`ifdef MUL_SEQ_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*W-1:0] sb_q[$];
    int             checks = 0;
    int             errors = 0;
    int             last_acc = 0;
    bit             have_acc = 1'b0;
    logic [2*W-1:0] prev_out = '0;
    bit             exp_busy, exp_done;
    logic [2*W-1:0] exp_out;

    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, bit s);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[W-1]) sa = sa - (longint'(1) << W);
        if (s && b[W-1]) sb = sb - (longint'(1) << W);
        return (2*W)'(sa * sb);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            check("reset_out", out, 0);
            prev_out = '0;
        end else begin
            exp_busy = have_acc && (cyc < last_acc + W);
            exp_done = have_acc && (cyc == last_acc + W);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("busy_done_exclusive", busy & done, 0);
            if (done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_without_request: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    exp_out = sb_q.pop_front();
                    check("product", out, exp_out);
                end
            end else begin
                check("out_hold", out, prev_out);
            end
            prev_out = out;
        end
    end

    // One clock of stimulus; the bench's own timing model decides whether start is taken.
    task automatic step(bit st, logic [W-1:0] xv, logic [W-1:0] yv, bit sv);
        bit s;
        s = sv;
`ifndef MUL_SEQ_SIGNED_EN
        s = 1'b0;
`endif
        start = st;
        x     = xv;
        y     = yv;
        sgn   = s;
        @(posedge clk);
        #1;
        if (st && rst_n && (!have_acc || cyc > last_acc + W)) begin
            sb_q.push_back(ref_mul(xv, yv, s));
            last_acc = cyc;
            have_acc = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) step(1'b0, '0, '0, 1'b0);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b0);

        step(1'b1, 5'd31, 5'd31, 1'b0);
        drain();
        check("max_product_held", out, 961);

        step(1'b1, 5'd0, 5'd27, 1'b0);
        drain();
        step(1'b1, 5'd13, 5'd7, 1'b0);
        drain();

        step(1'b1, 5'd3, 5'd5, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, 5'd9, 5'd9, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        drain();
        check("ignored_start_result", out, 15);

        step(1'b1, 5'd31, 5'd31, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_out", out, 0);
        sb_q.delete();
        have_acc = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) step(1'b0, '0, '0, 1'b0);

        step(1'b1, 5'd2, 5'd3, 1'b0);
        repeat (W + 1) step(1'b1, 5'd4, 5'd4, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        drain();
        check("back_to_back_last", out, 16);

`ifdef MUL_SEQ_SIGNED_EN
        step(1'b1, 5'b10000, 5'b10000, 1'b1);
        drain();
        step(1'b1, 5'b11111, 5'd5, 1'b1);
        drain();
        check("signed_neg5", out, 10'h3FB);
        step(1'b1, 5'b11111, 5'd5, 1'b0);
        drain();
        check("unsigned_155", out, 155);
`endif

        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 2) != 0, W'($urandom), W'($urandom), 1'($urandom));
        end
        step(1'b0, '0, '0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
